// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator with a pixel request port
// and a three-stage output pipeline (request, upstream fetch, output register).
// Optional feature: define VGA_TEST_PATTERN_EN to add i_pattern_sel, which replaces
// the upstream pixel data with eight vertical colour bars.
module vga_timing_gen #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        i_vga_clk,
    input  logic        i_sys_rst,
    input  logic [15:0] i_pix_data_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        i_pattern_sel,
`endif
    output logic        o_pix_req,
    output logic [9:0]  o_pix_x,
    output logic [9:0]  o_pix_y,
    output logic        o_frame_start,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [15:0] o_rgb
);

    // Both totals must not exceed 1024 so the 10-bit counters can hold them.
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0]  H_ACT_BEG   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  V_ACT_BEG   = 10'(V_SYNC + V_BACK);
    // End bounds are 11 bits wide so a region ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);

    // Raster counters
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        w_h_last;
    logic        w_v_last;

    // Region decode and stage 1 next-state
    logic        w_h_sync;
    logic        w_v_sync;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_req;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic        w_fs;

    // Stage 1
    logic        r_pix_req;
    logic [9:0]  r_pix_x;
    logic [9:0]  r_pix_y;
    logic        r_frame_start;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_de1;

    // Stage 2
    logic        r_hs2;
    logic        r_vs2;
    logic        r_de2;

    // Stage 3
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [15:0] r_rgb;
    logic [15:0] w_rgb_next;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W_I = ((H_ACTIVE / 8) == 0) ? 1 : (H_ACTIVE / 8);
    localparam logic [9:0]  BAR_W   = 10'(BAR_W_I);

    logic [9:0]  r_x2;
    logic [2:0]  w_bar_idx;
    logic [15:0] w_bar_rgb;
`endif

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Raster counters: v advances on h wrap, and both wrap together at the frame end.
    always_ff @(posedge i_vga_clk) begin
        if (i_sys_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    // Region decode from the counters; coordinates are zero outside the visible area.
    always_comb begin
        w_h_sync = (r_h_cnt < H_SYNC_END);
        w_v_sync = (r_v_cnt < V_SYNC_END);
        w_h_act  = (r_h_cnt >= H_ACT_BEG) && ({1'b0, r_h_cnt} < H_ACT_END);
        w_v_act  = (r_v_cnt >= V_ACT_BEG) && ({1'b0, r_v_cnt} < V_ACT_END);
        w_req    = w_h_act && w_v_act;
        w_x      = w_req ? (r_h_cnt - H_ACT_BEG) : 10'd0;
        w_y      = w_req ? (r_v_cnt - V_ACT_BEG) : 10'd0;
        w_fs     = w_req && (w_x == 10'd0) && (w_y == 10'd0);
    end

    // Stage 1: pixel request to upstream, with sync/de carried alongside.
    always_ff @(posedge i_vga_clk) begin
        if (i_sys_rst) begin
            r_pix_req     <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            r_de1         <= 1'b0;
        end else begin
            r_pix_req     <= w_req;
            r_pix_x       <= w_x;
            r_pix_y       <= w_y;
            r_frame_start <= w_fs;
            r_hs1         <= ~w_h_sync;
            r_vs1         <= ~w_v_sync;
            r_de1         <= w_req;
        end
    end

    // Stage 2: hold timing for the cycle in which upstream returns the pixel.
    always_ff @(posedge i_vga_clk) begin
        if (i_sys_rst) begin
            r_hs2 <= 1'b1;
            r_vs2 <= 1'b1;
            r_de2 <= 1'b0;
        end else begin
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_de2 <= r_de1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Pattern column tracks the pixel whose data is being captured this cycle.
    always_ff @(posedge i_vga_clk) begin
        if (i_sys_rst) begin
            r_x2 <= '0;
        end else begin
            r_x2 <= r_pix_x;
        end
    end

    assign w_bar_idx = 3'(r_x2 / BAR_W);

    // Colour bar lookup, white to black.
    always_comb begin
        case (w_bar_idx)
            3'd0:    w_bar_rgb = 16'hFFFF;
            3'd1:    w_bar_rgb = 16'hFFE0;
            3'd2:    w_bar_rgb = 16'h07FF;
            3'd3:    w_bar_rgb = 16'h07E0;
            3'd4:    w_bar_rgb = 16'hF81F;
            3'd5:    w_bar_rgb = 16'hF800;
            3'd6:    w_bar_rgb = 16'h001F;
            default: w_bar_rgb = 16'h0000;
        endcase
    end
`endif

    // Stage 3 data select: only visible pixels carry colour, blanking is forced black.
    always_comb begin
        w_rgb_next = 16'h0000;
        if (r_de2) begin
`ifdef VGA_TEST_PATTERN_EN
            w_rgb_next = i_pattern_sel ? w_bar_rgb : i_pix_data_in;
`else
            w_rgb_next = i_pix_data_in;
`endif
        end
    end

    // Stage 3: output registers keep sync, de and rgb mutually aligned.
    always_ff @(posedge i_vga_clk) begin
        if (i_sys_rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= r_hs2;
            r_vsync <= r_vs2;
            r_de    <= r_de2;
            r_rgb   <= w_rgb_next;
        end
    end

    assign o_pix_req     = r_pix_req;
    assign o_pix_x       = r_pix_x;
    assign o_pix_y       = r_pix_y;
    assign o_frame_start = r_frame_start;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_rgb         = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. A full-size instance is checked against a table of
// hand-computed vectors indexed by cycle after reset; a shrunken instance (25x13 raster)
// is run for two whole frames under a monitor and then reset mid-frame.
// Cycle c = number of clock edges since the last reset edge; outputs are sampled at negedge.
`timescale 1ns/1ps
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_big;
    logic        rst_small;
    logic        pat_big;
    logic        pat_small;
    logic [15:0] data_big   = 16'h0000;
    logic [15:0] data_small = 16'h0000;

    logic        big_req, big_fs, big_hs, big_vs, big_de;
    logic [9:0]  big_x, big_y;
    logic [15:0] big_rgb;
    logic        sm_req, sm_fs, sm_hs, sm_vs, sm_de;
    logic [9:0]  sm_x, sm_y;
    logic [15:0] sm_rgb;

    vga_timing_gen u_big (
        .i_vga_clk     (clk),
        .i_sys_rst     (rst_big),
        .i_pix_data_in (data_big),
`ifdef VGA_TEST_PATTERN_EN
        .i_pattern_sel (pat_big),
`endif
        .o_pix_req     (big_req),
        .o_pix_x       (big_x),
        .o_pix_y       (big_y),
        .o_frame_start (big_fs),
        .o_hsync       (big_hs),
        .o_vsync       (big_vs),
        .o_de          (big_de),
        .o_rgb         (big_rgb)
    );

    vga_timing_gen #(
        .H_SYNC   (4),
        .H_BACK   (3),
        .H_ACTIVE (16),
        .H_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (3),
        .V_ACTIVE (6),
        .V_FRONT  (2)
    ) u_small (
        .i_vga_clk     (clk),
        .i_sys_rst     (rst_small),
        .i_pix_data_in (data_small),
`ifdef VGA_TEST_PATTERN_EN
        .i_pattern_sel (pat_small),
`endif
        .o_pix_req     (sm_req),
        .o_pix_x       (sm_x),
        .o_pix_y       (sm_y),
        .o_frame_start (sm_fs),
        .o_hsync       (sm_hs),
        .o_vsync       (sm_vs),
        .o_de          (sm_de),
        .o_rgb         (sm_rgb)
    );

    // Upstream frame source: one-cycle latency, junk when nothing is requested.
    always @(posedge clk) begin
        data_big   <= big_req ? {big_y[5:0], big_x} : 16'hDEAD;
        data_small <= sm_req ? {sm_y[5:0], sm_x} : 16'hBEEF;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Observation word {hsync, vsync, de, rgb, pix_req, pix_x, pix_y, frame_start}
    function automatic logic [40:0] pack(input logic hs, input logic vs, input logic de,
                                         input logic [15:0] rgb, input logic req,
                                         input logic [9:0] x, input logic [9:0] y,
                                         input logic fs);
        return {hs, vs, de, rgb, req, x, y, fs};
    endfunction

    function automatic logic [40:0] big_obs();
        return pack(big_hs, big_vs, big_de, big_rgb, big_req, big_x, big_y, big_fs);
    endfunction

    function automatic logic [40:0] sm_obs();
        return pack(sm_hs, sm_vs, sm_de, sm_rgb, sm_req, sm_x, sm_y, sm_fs);
    endfunction

    function automatic logic [15:0] sel(input logic [15:0] pat_val, input logic [15:0] data_val);
        return PAT_EN ? pat_val : data_val;
    endfunction

    typedef struct {
        int          cyc;
        logic        pat;
        logic [40:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input int c, input logic p, input logic hs, input logic vs,
                           input logic de, input logic [15:0] rgb, input logic req,
                           input logic [9:0] x, input logic [9:0] y, input logic fs);
        vec_t v;
        v.cyc = c;
        v.pat = p;
        v.exp = pack(hs, vs, de, rgb, req, x, y, fs);
        vecs.push_back(v);
    endtask

    // ---------------- Small-instance monitor (H_TOTAL 25, V_TOTAL 13) ----------------
    logic        mon_en = 1'b0;
    int          m_cyc, hs_last_fall, hs_low, hs_bad, hs_falls;
    int          vs_last_fall, vs_low, vs_bad, vs_falls;
    int          de_run, de_runs, de_bad, de_total;
    int          req_total, x_bad, fs_cnt, fs_bad, data_bad;
    logic        m_hs_p, m_vs_p, m_req_p;
    logic [9:0]  m_x_p;
    logic [15:0] sb[$];

    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (!sm_hs) hs_low++;
            if (m_hs_p && !sm_hs) begin
                hs_falls++;
                if (hs_last_fall >= 0 && (m_cyc - hs_last_fall) != 25) hs_bad++;
                hs_last_fall = m_cyc;
            end
            if (!m_hs_p && sm_hs) begin
                if (hs_low != 4) hs_bad++;
                hs_low = 0;
            end
            if (!sm_vs) vs_low++;
            if (m_vs_p && !sm_vs) begin
                vs_falls++;
                if (vs_last_fall >= 0 && (m_cyc - vs_last_fall) != 325) vs_bad++;
                if (!(m_hs_p && !sm_hs)) vs_bad++;
                vs_last_fall = m_cyc;
            end
            if (!m_vs_p && sm_vs) begin
                if (vs_low != 50) vs_bad++;
                if (!(m_hs_p && !sm_hs)) vs_bad++;
                vs_low = 0;
            end
            if (sm_de) begin
                de_run++;
                de_total++;
                if (sb.size() == 0) data_bad++;
                else if (sm_rgb !== sb.pop_front()) data_bad++;
            end else begin
                if (sm_rgb !== 16'h0000) data_bad++;
                if (de_run != 0) begin
                    if (de_run != 16) de_bad++;
                    de_runs++;
                    de_run = 0;
                end
            end
            if (sm_req) begin
                req_total++;
                sb.push_back({sm_y[5:0], sm_x});
                if (m_req_p ? (sm_x != m_x_p + 10'd1) : (sm_x != 10'd0)) x_bad++;
                if (sm_x == 10'd0 && sm_y == 10'd0 && !sm_fs) fs_bad++;
            end else if (sm_x != 10'd0 || sm_y != 10'd0) begin
                x_bad++;
            end
            if (sm_fs) begin
                fs_cnt++;
                if (!sm_req || sm_x != 10'd0 || sm_y != 10'd0) fs_bad++;
            end
            m_hs_p  = sm_hs;
            m_vs_p  = sm_vs;
            m_req_p = sm_req;
            m_x_p   = sm_x;
            m_cyc++;
        end
    end

    logic [40:0] idle;
    int          cyc;
    int          vi;
    int          k;
    bit          seen;

    initial begin
        rst_big   = 1'b1;
        rst_small = 1'b1;
        pat_big   = 1'b0;
        pat_small = 1'b0;
        idle      = pack(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 10'd0, 10'd0, 1'b0);

        //       cyc    pat hs vs de rgb                       req x        y      fs
        add_vec(0,     0, 1, 1, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(2,     0, 1, 1, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(3,     0, 0, 0, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(98,    0, 0, 0, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(99,    0, 1, 0, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(1602,  0, 1, 0, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(1603,  0, 0, 1, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(28145, 0, 1, 1, 0, 16'h0000,                  1, 10'd0,   10'd0, 1);
        add_vec(28146, 0, 1, 1, 0, 16'h0000,                  1, 10'd1,   10'd0, 0);
        add_vec(28147, 0, 1, 1, 1, 16'h0000,                  1, 10'd2,   10'd0, 0);
        add_vec(28152, 0, 1, 1, 1, 16'h0005,                  1, 10'd7,   10'd0, 0);
        add_vec(28784, 0, 1, 1, 1, 16'h027D,                  1, 10'd639, 10'd0, 0);
        add_vec(28785, 0, 1, 1, 1, 16'h027E,                  0, 10'd0,   10'd0, 0);
        add_vec(28786, 0, 1, 1, 1, 16'h027F,                  0, 10'd0,   10'd0, 0);
        add_vec(28787, 0, 1, 1, 0, 16'h0000,                  0, 10'd0,   10'd0, 0);
        add_vec(28945, 0, 1, 1, 0, 16'h0000,                  1, 10'd0,   10'd1, 0);
        add_vec(28957, 0, 1, 1, 1, 16'h040A,                  1, 10'd12,  10'd1, 0);
        // Line y=3 with pattern_sel=1 (bars only when the pattern generator is built in)
        add_vec(30547, 1, 1, 1, 1, sel(16'hFFFF, 16'h0C00),   1, 10'd2,   10'd3, 0);
        add_vec(30626, 1, 1, 1, 1, sel(16'hFFFF, 16'h0C4F),   1, 10'd81,  10'd3, 0);
        add_vec(30627, 1, 1, 1, 1, sel(16'hFFE0, 16'h0C50),   1, 10'd82,  10'd3, 0);
        add_vec(30947, 1, 1, 1, 1, sel(16'hF800, 16'h0D90),   1, 10'd402, 10'd3, 0);
        add_vec(31026, 1, 1, 1, 1, sel(16'hF800, 16'h0DDF),   1, 10'd481, 10'd3, 0);
        add_vec(31107, 1, 1, 1, 1, sel(16'h0000, 16'h0E30),   1, 10'd562, 10'd3, 0);
        add_vec(31186, 1, 1, 1, 1, sel(16'h0000, 16'h0E7F),   0, 10'd0,   10'd0, 0);
        // Line y=4 with pattern_sel back to 0: pass-through restored
        add_vec(31352, 0, 1, 1, 1, 16'h1005,                  1, 10'd7,   10'd4, 0);

        // Reset held for 5 cycles: everything idle throughout.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("big_reset_idle", 64'(big_obs()), 64'(idle));
        end
        rst_big = 1'b0;
        cyc     = 0;
        vi      = 0;
        pat_big = vecs[0].pat;
        while (vi < vecs.size()) begin
            if (cyc == vecs[vi].cyc) begin
                check($sformatf("big_vec_cyc%0d", cyc), 64'(big_obs()), 64'(vecs[vi].exp));
                vi++;
                if (vi < vecs.size()) pat_big = vecs[vi].pat;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        pat_big = 1'b0;

        // Small instance: two whole frames under the monitor.
        m_cyc = 1; hs_last_fall = -1; hs_low = 0; hs_bad = 0; hs_falls = 0;
        vs_last_fall = -1; vs_low = 0; vs_bad = 0; vs_falls = 0;
        de_run = 0; de_runs = 0; de_bad = 0; de_total = 0;
        req_total = 0; x_bad = 0; fs_cnt = 0; fs_bad = 0; data_bad = 0;
        m_hs_p = 1'b1; m_vs_p = 1'b1; m_req_p = 1'b0; m_x_p = 10'd0;
        @(negedge clk);
        check("small_reset_idle", 64'(sm_obs()), 64'(idle));
        rst_small = 1'b0;
        mon_en    = 1'b1;
        cyc       = 0;
        while (cyc < 660) begin
            @(negedge clk);
            cyc++;
        end
        mon_en = 1'b0;
        check("small_hsync_falls",   64'(hs_falls),   64'(27));
        check("small_hsync_timing",  64'(hs_bad),     64'(0));
        check("small_vsync_falls",   64'(vs_falls),   64'(3));
        check("small_vsync_timing",  64'(vs_bad),     64'(0));
        check("small_de_run_len",    64'(de_bad),     64'(0));
        check("small_de_lines",      64'(de_runs),    64'(12));
        check("small_de_total",      64'(de_total),   64'(192));
        check("small_req_total",     64'(req_total),  64'(192));
        check("small_pix_x_contig",  64'(x_bad),      64'(0));
        check("small_frame_start_n", 64'(fs_cnt),     64'(2));
        check("small_frame_start_at",64'(fs_bad),     64'(0));
        check("small_rgb_data",      64'(data_bad),   64'(0));
        check("small_sb_drained",    64'(sb.size()),  64'(0));

        // Mid-frame reset at v=7, h=10 (counter 185 of the frame).
        while (cyc < 835) begin
            @(negedge clk);
            cyc++;
        end
        rst_small = 1'b1;
        @(negedge clk);
        check("small_midreset_idle", 64'(sm_obs()), 64'(idle));
        rst_small = 1'b0;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 2000) begin
            @(negedge clk);
            k++;
            if (k <= 2) check($sformatf("small_postreset_idle%0d", k), 64'(sm_obs()), 64'(idle));
            if (k == 3) check("small_postreset_hsync", 64'(sm_hs), 64'(0));
            if (sm_fs) seen = 1'b1;
        end
        // Edges after the release edge until frame_start: 7 + 5*25.
        check("small_restart_frame_start", 64'(seen ? k - 1 : -1), 64'(132));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480@60 Hz VGA raster timing in the 25 MHz `vga_clk` domain produced by the clock divider.
- Issues pixel read requests with coordinates to the upstream frame source and captures the returned RGB565 data.
- Drives `hsync`, `vsync`, `de` and `rgb` to the DAC/pins, all aligned to each other.
- Is the stage directly downstream of the clock divider.

## Interface
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BACK`, 48: horizontal back porch
- `H_ACTIVE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BACK`, 33: vertical back porch
- `V_ACTIVE`, 480: visible lines
- `V_FRONT`, 10: vertical front porch
- `vga_clk` in 1: pixel clock. One clock only; every register is clocked on its rising edge.
- `sys_rst` in 1: reset, synchronous and active-high.
- `pix_data_in` in 16: RGB565 from upstream, valid exactly 1 cycle after `pix_req`.
- `pix_req` out 1: request for pixel (`pix_x`, `pix_y`).
- `pix_x` out 10: requested column, 0..H_ACTIVE-1; 0 when `pix_req`=0.
- `pix_y` out 10: requested row, 0..V_ACTIVE-1; 0 when `pix_req`=0.
- `frame_start` out 1: one-cycle pulse together with the request for pixel (0,0).
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `de` out 1: display enable; high while `rgb` carries a visible pixel.
- `rgb` out 16: RGB565 output; 0 when `de`=0.

## Operation
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525). Both totals must be ≤ 1024.
- `h_cnt` counts 0..H_TOTAL-1, 10-bit, and wraps to 0.
- `v_cnt` increments only when `h_cnt` wraps. It counts 0..V_TOTAL-1 and wraps to 0 together with `h_cnt` (frame boundary).
- Regions derived from the counters:
  - sync: `h_cnt` < H_SYNC
  - active-h: H_SYNC+H_BACK ≤ `h_cnt` < H_SYNC+H_BACK+H_ACTIVE
  - Vertical regions are analogous on `v_cnt`.
- Stage 1 (registered from the counters):
  - `pix_req` = active-h AND active-v.
  - `pix_x` = `h_cnt` − (H_SYNC+H_BACK); `pix_y` = `v_cnt` − (V_SYNC+V_BACK). Both are forced to 0 when not requesting.
  - `frame_start` = request AND `pix_x`=0 AND `pix_y`=0.
  - Internal hsync/vsync/de are delayed in step with this stage.
- Stage 2: internal hsync/vsync/de are delayed one more cycle while upstream returns data.
- Stage 3 (output registers):
  - `hsync`, `vsync` and `de` take the delayed values.
  - `rgb` = `pix_data_in` when the delayed de is 1, else 0.
- Reset (`sys_rst`=1 at an edge):
  - Counters go to 0.
  - All pipeline stages flush: `pix_req`=0, `pix_x`=0, `pix_y`=0, `frame_start`=0, `hsync`=1, `vsync`=1, `de`=0, `rgb`=0.
  - Reset has priority over counting.
- Reset mid-frame: the frame is abandoned. No partial-pipeline data appears after reset. Timing restarts at `h_cnt`=0, `v_cnt`=0.

## Timing
- Line period: H_TOTAL cycles. `hsync` is low for H_SYNC consecutive cycles per line.
- Frame period: H_TOTAL·V_TOTAL = 420000 cycles. `vsync` is low for V_SYNC·H_TOTAL = 1600 cycles, and its edges coincide with `hsync` falling edges.
- `pix_req` is high for H_ACTIVE consecutive cycles on each of V_ACTIVE lines, with `pix_x` incrementing by 1 per cycle.
- Request in cycle n → `pix_data_in` sampled at the end of cycle n+1 → `rgb`/`de` driven in cycle n+2.
- Outputs lag the counters by 3 cycles. `hsync`, `vsync`, `de` and `rgb` are always mutually aligned.
- After reset release, the first `hsync` low appears in cycle 3, with cycle 0 being the first cycle with counters at 0 and not in reset. The first `frame_start` occurs at `h_cnt`=144, `v_cnt`=35, presented in the cycle after.
- `frame_start` and the first `pix_req` of a frame are the same cycle.

## Configuration
- Macro: `VGA_TEST_PATTERN_EN`.
- Defined:
  - Adds input `pattern_sel` (1 bit).
  - When `pattern_sel`=1, stage 3 outputs 8 vertical bars of H_ACTIVE/8 pixels each, indexed from the delayed `pix_x`: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - `pix_data_in` is ignored in pattern mode, but `pix_req` still toggles normally.
  - `pattern_sel` is sampled per pixel, so a change takes effect within 3 cycles.
- Undefined: no `pattern_sel` port; `rgb` always comes from `pix_data_in`.

## Test plan
- **Reset values:** hold `sys_rst`=1 for 5 cycles → `hsync`=1, `vsync`=1, `de`=0, `rgb`=0, `pix_req`=0, `pix_x`=0, `pix_y`=0, `frame_start`=0 throughout.
- **Line and frame timing:** run 2 frames → `hsync` period 800 cycles, low for 96. `vsync` period 420000, low for 1600. `de` high for 640 cycles/line on 480 lines per frame.
- **Requests and data path:** upstream is a 1-cycle-latency model returning `{pix_y[5:0], pix_x}` → 640·480 requests per frame, `pix_x` 0..639 contiguous. Every `rgb` with `de`=1 equals the model value for the pixel requested 2 cycles earlier. `frame_start` is exactly 1 pulse per frame, at (0,0).
- **Reset mid-frame:** assert `sys_rst` for 1 cycle at `v_cnt`=200, `h_cnt`=300 → outputs idle next cycle. The next `frame_start` arrives exactly 144+35·800 cycles after reset release.
- **Test pattern (`VGA_TEST_PATTERN_EN` defined):** with `pattern_sel`=1 → `rgb`=FFFF for `pix_x` 0..79, F800 for 400..479, 0000 for 560..639. `pattern_sel`=0 restores the pass-through data.
